// File: rtl/alarm_set_ctrl.sv
// Alarm-time editing controller: steps hours/minutes with button pulses, drives
// the hold-to-save counter enable, and commits the edited time on its completion.
module alarm_set_ctrl #(
  parameter int TIMEOUT_TICKS = 30,
  parameter int HH_MAX        = 23,
  parameter int MM_MAX        = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_save,
  input  logic       save_done,
  output logic       save_hold,
  output logic [4:0] edit_hh,
  output logic [5:0] edit_mm,
  output logic [1:0] editing,
  output logic [4:0] alarm_hh,
  output logic [5:0] alarm_mm,
  output logic       alarm_valid,
  output logic       saved_pulse
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EDIT_HH   = 2'd1,
    EDIT_MM   = 2'd2,
    HOLD_SAVE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        r_ret_state;
  logic [TW-1:0] r_to_cnt;
  logic [4:0]    r_edit_hh;
  logic [5:0]    r_edit_mm;
  logic [4:0]    r_alarm_hh;
  logic [5:0]    r_alarm_mm;
  logic          r_alarm_valid;
  logic          r_saved_pulse;

  function automatic logic [4:0] inc_hh(input logic [4:0] v);
    return (v >= 5'(HH_MAX)) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [5:0] inc_mm(input logic [5:0] v);
    return (v >= 6'(MM_MAX)) ? 6'd0 : v + 6'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ret_state   <= EDIT_HH;
      r_to_cnt      <= '0;
      r_edit_hh     <= '0;
      r_edit_mm     <= '0;
      r_alarm_hh    <= '0;
      r_alarm_mm    <= '0;
      r_alarm_valid <= 1'b0;
      r_saved_pulse <= 1'b0;
    end else begin
      r_saved_pulse <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (btn_mode) begin
            r_state   <= EDIT_HH;
            r_edit_hh <= r_alarm_hh;
            r_edit_mm <= r_alarm_mm;
            r_to_cnt  <= '0;
          end
        end
        EDIT_HH, EDIT_MM: begin
          if (btn_save) begin
            r_ret_state <= r_state;
            r_state     <= HOLD_SAVE;
          end else if (btn_mode) begin
            r_state  <= (r_state == EDIT_HH) ? EDIT_MM : EDIT_HH;
            r_to_cnt <= '0;
          end else if (btn_inc) begin
            if (r_state == EDIT_HH) r_edit_hh <= inc_hh(r_edit_hh);
            else                    r_edit_mm <= inc_mm(r_edit_mm);
            r_to_cnt <= '0;
          end else if (tick_1hz) begin
            // The tick that brings the count up to TIMEOUT_TICKS abandons the edit.
            if (r_to_cnt >= TW'(TIMEOUT_TICKS - 1)) begin
              r_state  <= IDLE;
              r_to_cnt <= '0;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
        end
        HOLD_SAVE: begin
          if (save_done) begin
            r_alarm_hh    <= r_edit_hh;
            r_alarm_mm    <= r_edit_mm;
            r_alarm_valid <= 1'b1;
            r_saved_pulse <= 1'b1;
            r_state       <= IDLE;
          end else if (!btn_save) begin
            r_state  <= r_ret_state;
            r_to_cnt <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign save_hold   = (r_state == HOLD_SAVE);
  assign editing     = r_state;
  assign edit_hh     = r_edit_hh;
  assign edit_mm     = r_edit_mm;
  assign alarm_hh    = r_alarm_hh;
  assign alarm_mm    = r_alarm_mm;
  assign alarm_valid = r_alarm_valid;
  assign saved_pulse = r_saved_pulse;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Directed bench for alarm_set_ctrl with a shortened timeout; expected values
// are hand-computed per step.
module tb_alarm_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz, btn_mode, btn_inc, btn_save, save_done;
  logic       save_hold;
  logic [4:0] edit_hh, alarm_hh;
  logic [5:0] edit_mm, alarm_mm;
  logic [1:0] editing;
  logic       alarm_valid, saved_pulse;

  int checks   = 0;
  int failures = 0;

  alarm_set_ctrl #(.TIMEOUT_TICKS(4), .HH_MAX(23), .MM_MAX(59)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
    .btn_inc(btn_inc), .btn_save(btn_save), .save_done(save_done),
    .save_hold(save_hold), .edit_hh(edit_hh), .edit_mm(edit_mm),
    .editing(editing), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .alarm_valid(alarm_valid), .saved_pulse(saved_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs sampled at the edge, pulse inputs cleared 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
    btn_mode  = 1'b0;
    btn_inc   = 1'b0;
    tick_1hz  = 1'b0;
    save_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick_1hz = 0; btn_mode = 0; btn_inc = 0; btn_save = 0; save_done = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_editing", editing, 0);
    chk("rst_save_hold", save_hold, 0);
    chk("rst_alarm_valid", alarm_valid, 0);
    chk("rst_alarm_hh", alarm_hh, 0);
    chk("rst_saved_pulse", saved_pulse, 0);

    // Enter edit
    btn_mode = 1; step();
    chk("enter_editing", editing, 1);
    chk("enter_edit_hh", edit_hh, 0);
    chk("enter_edit_mm", edit_mm, 0);
    chk("enter_save_hold", save_hold, 0);
    chk("enter_alarm_valid", alarm_valid, 0);

    // Hours step to 23 then wrap to 0
    for (int i = 1; i <= 24; i++) begin
      btn_inc = 1; step();
      if (i == 23) chk("hh_at_max", edit_hh, 23);
    end
    chk("hh_wrap", edit_hh, 0);

    // Minutes: 61 increments wrap past 59 to 1
    btn_mode = 1; step();
    chk("toggle_to_mm", editing, 2);
    for (int i = 1; i <= 61; i++) begin
      btn_inc = 1; step();
      if (i == 59) chk("mm_at_max", edit_mm, 59);
    end
    chk("mm_wrap", edit_mm, 1);
    chk("hh_unchanged", edit_hh, 0);

    // Build 07:30
    for (int i = 0; i < 29; i++) begin btn_inc = 1; step(); end
    btn_mode = 1; step();
    for (int i = 0; i < 7; i++) begin btn_inc = 1; step(); end
    chk("set_hh", edit_hh, 7);
    chk("set_mm", edit_mm, 30);

    // Hold save; counter answers 5 clks after save_hold rises
    btn_save = 1; step();
    chk("hold_editing", editing, 3);
    chk("hold_save_hold", save_hold, 1);
    repeat (4) step();
    chk("hold_no_commit_yet", alarm_valid, 0);
    save_done = 1; step();
    chk("commit_hh", alarm_hh, 7);
    chk("commit_mm", alarm_mm, 30);
    chk("commit_valid", alarm_valid, 1);
    chk("commit_pulse", saved_pulse, 1);
    chk("commit_idle", editing, 0);
    chk("commit_hold_drop", save_hold, 0);
    btn_save = 0; step();
    chk("pulse_one_clk", saved_pulse, 0);
    chk("stay_idle", editing, 0);

    // Re-enter: edit fields load from committed alarm
    btn_mode = 1; step();
    chk("reload_hh", edit_hh, 7);
    chk("reload_mm", edit_mm, 30);
    btn_mode = 1; step();
    btn_inc = 1; step();
    chk("mm_inc", edit_mm, 31);

    // Hold then release early
    btn_save = 1; step();
    chk("hold2", editing, 3);
    repeat (2) step();
    btn_save = 0; step();
    chk("release_ret", editing, 2);
    chk("release_mm_kept", edit_mm, 31);
    chk("release_alarm_mm", alarm_mm, 30);
    chk("release_pulse", saved_pulse, 0);

    // save beats mode on the same clk
    btn_save = 1; btn_mode = 1; step();
    chk("save_prio", editing, 3);
    btn_save = 0; step();
    chk("save_prio_ret", editing, 2);

    // Timeout: 3 ticks, then inc coinciding with a tick restarts the count
    for (int i = 0; i < 3; i++) begin tick_1hz = 1; step(); step(); end
    chk("to_before_inc", editing, 2);
    btn_inc = 1; tick_1hz = 1; step();
    chk("to_inc_mm", edit_mm, 32);
    for (int i = 0; i < 3; i++) begin tick_1hz = 1; step(); step(); end
    chk("to_3_ticks", editing, 2);
    tick_1hz = 1; step();
    chk("to_idle", editing, 0);
    chk("to_alarm_mm", alarm_mm, 30);
    chk("to_alarm_hh", alarm_hh, 7);
    chk("to_valid", alarm_valid, 1);

    // Stray save_done in IDLE
    save_done = 1; step();
    chk("stray_pulse", saved_pulse, 0);
    chk("stray_alarm_mm", alarm_mm, 30);
    btn_mode = 1; step();
    chk("discard_mm", edit_mm, 30);
    chk("discard_editing", editing, 1);

    // Asynchronous reset during HOLD_SAVE
    btn_save = 1; step();
    chk("pre_rst_hold", save_hold, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_save_hold", save_hold, 0);
    chk("arst_editing", editing, 0);
    chk("arst_alarm_valid", alarm_valid, 0);
    chk("arst_alarm_hh", alarm_hh, 0);
    chk("arst_alarm_mm", alarm_mm, 0);
    btn_save = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_idle", editing, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_set_ctrl.md
Name: alarm_set_ctrl

Overview:
Alarm-time editing controller that sits directly upstream of the hold-to-save five-second counter. It lets the user step the alarm hours and minutes with push-button pulses. While the save button is held it drives the counter's enable. When the counter reports completion, it commits the edited time to the alarm registers that feed the alarm comparator.

Parameters:
TIMEOUT_TICKS, 30, number of tick_1hz pulses without button activity in an edit state before the edit is abandoned
HH_MAX, 23, largest hour value; hours wrap HH_MAX -> 0
MM_MAX, 59, largest minute value; minutes wrap MM_MAX -> 0

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
tick_1hz  in  1  one-clk-wide pulse once per second; timeout timebase
btn_mode  in  1  debounced one-clk pulse: enter edit / toggle field
btn_inc  in  1  debounced one-clk pulse: increment selected field
btn_save  in  1  debounced level, high while save button held
save_done  in  1  completion pulse from the five-second counter
save_hold  out  1  enable to the five-second counter; high only in HOLD_SAVE
edit_hh  out  5  hour value being edited
edit_mm  out  6  minute value being edited
editing  out  2  display select: 0 none, 1 hours, 2 minutes, 3 saving
alarm_hh  out  5  committed alarm hour
alarm_mm  out  6  committed alarm minute
alarm_valid  out  1  high once any alarm has been committed
saved_pulse  out  1  one-clk pulse on commit, for the beeper/LED

Behaviour:
- Reset (async): state IDLE; edit_hh/edit_mm/alarm_hh/alarm_mm = 0; alarm_valid = 0; saved_pulse = 0; timeout count = 0; return-state = EDIT_HH.
- All outputs are registered or decoded from the state register (Moore). There are no combinational paths from inputs to outputs.
- States: IDLE, EDIT_HH, EDIT_MM, HOLD_SAVE. editing = 0/1/2/3 respectively. save_hold = (state == HOLD_SAVE).
- IDLE:
  - btn_mode -> EDIT_HH. On the same edge, edit_hh <= alarm_hh and edit_mm <= alarm_mm.
  - btn_inc, btn_save and save_done are ignored.
- EDIT_HH / EDIT_MM, priority btn_save > btn_mode > btn_inc, one action per clk:
  - btn_save high -> HOLD_SAVE; record the current state as the return-state.
  - btn_mode -> toggle to the other edit state.
  - btn_inc -> selected field +1. At the field max it wraps to 0 (23 -> 0, 59 -> 0). The unselected field is unchanged.
- Timeout (edit states only):
  - The counter clears on entry to an edit state and on any accepted btn_mode/btn_inc. It increments on tick_1hz.
  - When the count reaches TIMEOUT_TICKS -> IDLE. Edits are discarded; alarm_* and alarm_valid are unchanged.
  - A tick_1hz coinciding with a button pulse clears the counter; the button wins.
  - Counter width is ceil(log2(TIMEOUT_TICKS+1)).
- HOLD_SAVE:
  - save_done high (checked first) -> commit on that edge: alarm_hh <= edit_hh, alarm_mm <= edit_mm, alarm_valid <= 1, saved_pulse = 1 for the next clk only. Then -> IDLE.
  - Else btn_save low -> return-state, edits kept, timeout cleared.
  - btn_mode, btn_inc and tick_1hz are ignored.
  - save_done arriving in any state other than HOLD_SAVE is ignored.
- save_hold drops in the clk after commit or release, so the counter reloads for the next hold. A counter with 5-clk latency produces save_done 5 clks after save_hold rises.
- Reset mid-edit or mid-hold: immediate return to reset values; committed alarm is lost (no retention).

Test Plan:
- Reset, then btn_mode -> editing=1, edit_hh=0, edit_mm=0, save_hold=0, alarm_valid=0.
- In EDIT_HH, 24 btn_inc pulses -> edit_hh steps to 23 then wraps to 0. Then btn_mode plus 61 btn_inc pulses -> edit_mm=1, edit_hh=0.
- Set edit 07:30, hold btn_save, model the counter returning save_done 5 clks after save_hold -> commit gives alarm_hh=7, alarm_mm=30, alarm_valid=1, saved_pulse high exactly 1 clk, state IDLE.
- Hold btn_save, release after 3 clks (no save_done) -> return to the prior edit state, alarm_* unchanged, edit values kept. Same-clk btn_save+btn_mode -> HOLD_SAVE entered, no field toggle.
- TIMEOUT_TICKS=4: in EDIT_MM with 4 tick_1hz and no buttons -> IDLE, edits discarded. A btn_inc before the 4th tick restarts the count. Stray save_done in IDLE -> no commit.
- Assert rst_n low during HOLD_SAVE -> outputs return to reset values asynchronously, save_hold low before the next clk edge.
